// File: rtl/alu_sel_ctrl_pkg.sv
// Shared constants for the decode-to-EX ALU select stage: mux select codes,
// RV32I opcode values and the canonical NOP encoding.
package alu_sel_ctrl_pkg;

    localparam int ALU_IN_MUX_SEL_WIDTH = 3;

    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_RF     = 3'd0;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_IMM_I  = 3'd1;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_IMM_S  = 3'd2;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_IMM_U  = 3'd3;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_IMM_UJ = 3'd4;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_PC     = 3'd5;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_NULL   = 3'd6;
    localparam logic [ALU_IN_MUX_SEL_WIDTH-1:0] ALU_IN_MUX_FW_WB  = 3'd7;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic [4:0] rd_field(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/alu_sel_ctrl_decode.sv
// instr_field_decode: combinational opcode decode into ALU operand selects,
// register-use flags and destination write enable.
module instr_field_decode
    import alu_sel_ctrl_pkg::*;
(
    input  logic [31:0]                     instr,
    output logic [ALU_IN_MUX_SEL_WIDTH-1:0] sel1,
    output logic [ALU_IN_MUX_SEL_WIDTH-1:0] sel2,
    output logic                            rs1_used,
    output logic                            rs2_used,
    output logic                            rf_we,
    output logic [4:0]                      rd,
    output logic                            legal,
    output logic                            is_store
);

    logic writes_rd_s;
    logic unused_bits_s;

    assign unused_bits_s = ^{instr[31:12]};

    // Opcode table; unknown opcodes fall out as illegal and are issued as bubbles
    always_comb begin
        sel1        = ALU_IN_MUX_NULL;
        sel2        = ALU_IN_MUX_NULL;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        writes_rd_s = 1'b0;
        legal       = 1'b1;
        is_store    = 1'b0;
        case (instr[6:0])
            OPC_R: begin
                sel1 = ALU_IN_MUX_RF; sel2 = ALU_IN_MUX_RF;
                rs1_used = 1'b1; rs2_used = 1'b1; writes_rd_s = 1'b1;
            end
            OPC_I_ALU, OPC_LOAD, OPC_JALR: begin
                sel1 = ALU_IN_MUX_RF; sel2 = ALU_IN_MUX_IMM_I;
                rs1_used = 1'b1; writes_rd_s = 1'b1;
            end
            OPC_STORE: begin
                sel1 = ALU_IN_MUX_RF; sel2 = ALU_IN_MUX_IMM_S;
                rs1_used = 1'b1; rs2_used = 1'b1; is_store = 1'b1;
            end
            OPC_BRANCH: begin
                sel1 = ALU_IN_MUX_RF; sel2 = ALU_IN_MUX_RF;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LUI: begin
                sel1 = ALU_IN_MUX_NULL; sel2 = ALU_IN_MUX_IMM_U; writes_rd_s = 1'b1;
            end
            OPC_AUIPC: begin
                sel1 = ALU_IN_MUX_PC; sel2 = ALU_IN_MUX_IMM_U; writes_rd_s = 1'b1;
            end
            OPC_JAL: begin
                sel1 = ALU_IN_MUX_PC; sel2 = ALU_IN_MUX_IMM_UJ; writes_rd_s = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // x0 is never a real destination, so it never produces a write or hazard
    always_comb begin
        rf_we = writes_rd_s && (rd_field(instr) != 5'd0);
        if (rf_we) begin
            rd = rd_field(instr);
        end else begin
            rd = 5'd0;
        end
    end

endmodule

// File: rtl/alu_sel_ctrl.sv
// alu_sel_ctrl: decode-to-EX register stage with RAW hazard handling.
// Define ALU_SEL_FORWARDING_EN to resolve hazards by writeback forwarding instead of stalling.
module alu_sel_ctrl
    import alu_sel_ctrl_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     dec_instr,
    input  logic [31:0]                     dec_pc,
    input  logic                            dec_valid,
    input  logic                            flush,
    output logic                            stall,
    output logic [31:0]                     ex_instr,
    output logic [31:0]                     ex_pc,
    output logic                            ex_valid,
    output logic [ALU_IN_MUX_SEL_WIDTH-1:0] mux_1_sel,
    output logic [ALU_IN_MUX_SEL_WIDTH-1:0] mux_2_sel,
    output logic                            ex_rf_we,
    output logic [4:0]                      ex_rd,
    output logic                            ex_fw_store_data,
    output logic [31:0]                     hazard_cycles
);

    logic [ALU_IN_MUX_SEL_WIDTH-1:0] dec_sel1_s, dec_sel2_s, iss_sel1_s, iss_sel2_s;
    logic                            dec_rs1_used_s, dec_rs2_used_s, dec_rf_we_s;
    logic                            dec_legal_s, dec_is_store_s;
    logic [4:0]                      dec_rd_s;
    logic                            haz_rs1_s, haz_rs2_s, iss_fw_s, stall_s, issue_s;

    logic [31:0]                     ex_instr_r, ex_pc_r, hazard_cycles_r;
    logic [ALU_IN_MUX_SEL_WIDTH-1:0] ex_sel1_r, ex_sel2_r;
    logic                            ex_valid_r, ex_rf_we_r, ex_fw_r;
    logic [4:0]                      ex_rd_r;

    instr_field_decode u_decode (
        .instr    (dec_instr),
        .sel1     (dec_sel1_s),
        .sel2     (dec_sel2_s),
        .rs1_used (dec_rs1_used_s),
        .rs2_used (dec_rs2_used_s),
        .rf_we    (dec_rf_we_s),
        .rd       (dec_rd_s),
        .legal    (dec_legal_s),
        .is_store (dec_is_store_s)
    );

    // Only the EX producer can hazard; WB is covered by the write-through register file
    always_comb begin
        haz_rs1_s = dec_valid && ex_valid_r && ex_rf_we_r && dec_rs1_used_s
                    && (dec_instr[19:15] == ex_rd_r);
        haz_rs2_s = dec_valid && ex_valid_r && ex_rf_we_r && dec_rs2_used_s
                    && (dec_instr[24:20] == ex_rd_r);
    end

`ifdef ALU_SEL_FORWARDING_EN
    // Redirect hazarded ALU operands to the writeback path; store data forwards separately
    always_comb begin
        stall_s = 1'b0;
        if (haz_rs1_s) begin
            iss_sel1_s = ALU_IN_MUX_FW_WB;
        end else begin
            iss_sel1_s = dec_sel1_s;
        end
        if (haz_rs2_s && (dec_sel2_s == ALU_IN_MUX_RF)) begin
            iss_sel2_s = ALU_IN_MUX_FW_WB;
        end else begin
            iss_sel2_s = dec_sel2_s;
        end
        iss_fw_s = haz_rs2_s && dec_is_store_s;
    end
`else
    logic unused_store_s;
    assign unused_store_s = dec_is_store_s;

    // Without forwarding any hazard holds decode for one cycle; reset and flush override
    always_comb begin
        stall_s    = (haz_rs1_s || haz_rs2_s) && !flush && !rst;
        iss_sel1_s = dec_sel1_s;
        iss_sel2_s = dec_sel2_s;
        iss_fw_s   = 1'b0;
    end
`endif

    assign issue_s = dec_valid && dec_legal_s && !flush && !stall_s;

    // EX slot: load the decoded instruction or a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r <= 1'b0;
            ex_instr_r <= NOP_INSTR;
            ex_pc_r    <= 32'd0;
            ex_sel1_r  <= ALU_IN_MUX_NULL;
            ex_sel2_r  <= ALU_IN_MUX_NULL;
            ex_rf_we_r <= 1'b0;
            ex_rd_r    <= 5'd0;
            ex_fw_r    <= 1'b0;
        end else if (issue_s) begin
            ex_valid_r <= 1'b1;
            ex_instr_r <= dec_instr;
            ex_pc_r    <= dec_pc;
            ex_sel1_r  <= iss_sel1_s;
            ex_sel2_r  <= iss_sel2_s;
            ex_rf_we_r <= dec_rf_we_s;
            ex_rd_r    <= dec_rd_s;
            ex_fw_r    <= iss_fw_s;
        end else begin
            ex_valid_r <= 1'b0;
            ex_instr_r <= NOP_INSTR;
            ex_pc_r    <= dec_pc;
            ex_sel1_r  <= ALU_IN_MUX_NULL;
            ex_sel2_r  <= ALU_IN_MUX_NULL;
            ex_rf_we_r <= 1'b0;
            ex_rd_r    <= 5'd0;
            ex_fw_r    <= 1'b0;
        end
    end

    // Stall-cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cycles_r <= 32'd0;
        end else if (stall_s) begin
            hazard_cycles_r <= hazard_cycles_r + 32'd1;
        end else begin
            hazard_cycles_r <= hazard_cycles_r;
        end
    end

    assign stall            = stall_s;
    assign ex_instr         = ex_instr_r;
    assign ex_pc            = ex_pc_r;
    assign ex_valid         = ex_valid_r;
    assign mux_1_sel        = ex_sel1_r;
    assign mux_2_sel        = ex_sel2_r;
    assign ex_rf_we         = ex_rf_we_r;
    assign ex_rd            = ex_rd_r;
    assign ex_fw_store_data = ex_fw_r;
    assign hazard_cycles    = hazard_cycles_r;

endmodule
